// File: rtl/gray_rx_checker.sv
// gray_rx_checker
//   Reader-side monitor for a gray-coded fifo pointer. The incoming code is
//   passed through a short synchroniser and decoded to binary. Each change is
//   checked to be a single +1 step (mod 2^WIDTH). Legal steps and wraps are
//   counted with saturating counters. An illegal change raises a one-cycle
//   error pulse and a sticky flag, and tracking stops until errClr re-acquires.
//
// Ports
//   clk        in   1      rising-edge clock
//   rstN       in   1      asynchronous active-low reset
//   grayIn     in   WIDTH  gray code from the fifo counter
//   errClr     in   1      clear sticky error and re-acquire (level)
//   binOut     out  WIDTH  registered binary decode of the synchronised code
//   binValid   out  1      binOut holds a tracked value
//   step       out  1      pulse: legal +1 advance accepted
//   wrapPulse  out  1      pulse: legal advance from all-ones to zero
//   errPulse   out  1      pulse: illegal transition detected
//   errSticky  out  1      set by an error, held until errClr
//   stepCount  out  CNT_W  saturating count of legal steps
//   wrapCount  out  CNT_W  saturating count of wraps
module gray_rx_checker #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] grayIn,
  input  logic             errClr,
  output logic [WIDTH-1:0] binOut,
  output logic             binValid,
  output logic             step,
  output logic             wrapPulse,
  output logic             errPulse,
  output logic             errSticky,
  output logic [CNT_W-1:0] stepCount,
  output logic [CNT_W-1:0] wrapCount
);

  typedef enum logic [1:0] {FILL, ACQ, TRACK, FAULT} state_t;

  localparam int FILL_W = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

  state_t            state;
  state_t            nextState;
  logic [WIDTH-1:0]  syncGray;
  logic [WIDTH-1:0]  cur;
  logic [FILL_W-1:0] fillCnt;
  logic              fillDone;
  logic              doAcq;
  logic              accStep;
  logic              accWrap;
  logic              accErr;
  logic              clrSticky;

  // Synchroniser chain; with zero stages the raw input feeds the decoder.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign syncGray = grayIn;
    end else begin : g_sync
      logic [WIDTH-1:0] syncReg [SYNC_STAGES];
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          for (int i = 0; i < SYNC_STAGES; i++) syncReg[i] <= '0;
        end else begin
          syncReg[0] <= grayIn;
          for (int i = 1; i < SYNC_STAGES; i++) syncReg[i] <= syncReg[i-1];
        end
      end
      assign syncGray = syncReg[SYNC_STAGES-1];
    end
  endgenerate

  // Binary bit i is the XOR of all gray bits from the MSB down to bit i.
  always_comb begin
    cur = '0;
    for (int i = 0; i < WIDTH; i++) cur[i] = ^(syncGray >> i);
  end

  // FILL lasts SYNC_STAGES edges so ACQ sees data that entered after reset;
  // with fewer than two stages a single FILL edge is enough.
  assign fillDone = (SYNC_STAGES <= 1) ? 1'b1 : (fillCnt == FILL_W'(SYNC_STAGES - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= FILL;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    doAcq     = 1'b0;
    accStep   = 1'b0;
    accWrap   = 1'b0;
    accErr    = 1'b0;
    clrSticky = 1'b0;
    case (state)
      FILL: begin
        if (fillDone) nextState = ACQ;
      end
      ACQ: begin
        doAcq     = 1'b1;
        nextState = TRACK;
      end
      TRACK: begin
        if (cur == binOut) begin
          accStep = 1'b0;
        end else if (cur == binOut + WIDTH'(1)) begin
          accStep = 1'b1;
          accWrap = &binOut;
        end else begin
          accErr    = 1'b1;
          nextState = FAULT;
        end
      end
      FAULT: begin
        if (errClr) begin
          clrSticky = 1'b1;
          nextState = ACQ;
        end
      end
      default: nextState = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fillCnt   <= '0;
      binOut    <= '0;
      binValid  <= 1'b0;
      step      <= 1'b0;
      wrapPulse <= 1'b0;
      errPulse  <= 1'b0;
      errSticky <= 1'b0;
      stepCount <= '0;
      wrapCount <= '0;
    end else begin
      step      <= accStep;
      wrapPulse <= accWrap;
      errPulse  <= accErr;

      if (state == FILL && !fillDone) fillCnt <= fillCnt + FILL_W'(1);
      if (state != FILL) binOut <= cur;

      // binValid drops together with the error so an illegal binOut is never
      // presented as tracked.
      if (doAcq) begin
        binValid  <= 1'b1;
        stepCount <= '0;
        wrapCount <= '0;
      end else if (accErr || state == FAULT) begin
        binValid <= 1'b0;
      end

      if (accStep && stepCount != {CNT_W{1'b1}}) stepCount <= stepCount + CNT_W'(1);
      if (accWrap && wrapCount != {CNT_W{1'b1}}) wrapCount <= wrapCount + CNT_W'(1);

      if (accErr)         errSticky <= 1'b1;
      else if (clrSticky) errSticky <= 1'b0;
    end
  end

endmodule
